// File: rtl/regfile_sb_dump_if.sv
// Bus bundle for regfile_sb_dump: read ports, two writeback ports, scoreboard set,
// and the valid/ready dump stream.
//   master: issue/writeback/debug side (drives addresses, writes, dump_ready)
//   slave : the register file itself
interface regfile_sb_dump_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              sb_set_en;
  logic [ADDR_W-1:0] sb_set_addr;
  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;

  modport slave (
    input  rd_addr1, rd_addr2, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set_en, sb_set_addr, dump_start, dump_ready,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, dump_valid, dump_addr, dump_data,
           dump_busy
  );

  modport master (
    output rd_addr1, rd_addr2, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set_en, sb_set_addr, dump_start, dump_ready,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, dump_valid, dump_addr, dump_data,
           dump_busy
  );
endinterface

// File: rtl/regfile_sb_dump.sv
// Parametrised integer register file with two write ports (A has priority over B),
// two combinational read ports with optional write bypass, a per-entry busy
// scoreboard for issue hazard detection, and a LOAD/SEND streaming dump engine.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset (clears array, busy bits, dump engine)
//   bus   - regfile_sb_dump_if slave modport (reads, writes, scoreboard, dump stream)
module regfile_sb_dump #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_sb_dump_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  // Array and scoreboard next state
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i]  = mem_q[i];
      busy_d[i] = busy_q[i];
      // B first so that A overrides it on an address collision
      if (bus.wb_en && (bus.wb_addr == ADDR_W'(i))) begin
        mem_d[i]  = bus.wb_data;
        busy_d[i] = 1'b0;
      end
      if (bus.wa_en && (bus.wa_addr == ADDR_W'(i))) begin
        mem_d[i]  = bus.wa_data;
        busy_d[i] = 1'b0;
      end
      // Set after clear: the newly issued producer owns the register
      if (bus.sb_set_en && (bus.sb_set_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    if (ZERO_REG) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  // Read ports, handled uniformly through small arrays
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = bus.rd_addr1;
  assign rd_addr[1] = bus.rd_addr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic hit_a, hit_b;
      hit_a      = BYPASS && bus.wa_en && (bus.wa_addr == rd_addr[p]);
      hit_b      = BYPASS && bus.wb_en && (bus.wb_addr == rd_addr[p]);
      rd_data[p] = mem_q[rd_addr[p]];
      if (hit_a) begin
        rd_data[p] = bus.wa_data;
      end else if (hit_b) begin
        rd_data[p] = bus.wb_data;
      end
      // A same-cycle write resolves the hazard when it is being forwarded
      rd_busy[p] = busy_q[rd_addr[p]] && !(hit_a || hit_b);
      if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign bus.rd_data1 = rd_data[0];
  assign bus.rd_data2 = rd_data[1];
  assign bus.rd_busy1 = rd_busy[0];
  assign bus.rd_busy2 = rd_busy[1];

  // Dump engine
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.dump_start) begin
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Snapshot the pre-edge value so later writes cannot disturb the beat
        dump_addr_d = idx_q;
        dump_data_d = (ZERO_REG && (idx_q == '0)) ? '0 : mem_q[idx_q];
        state_d     = StSend;
      end
      StSend: begin
        if (bus.dump_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.dump_valid = (state_q == StSend);
  assign bus.dump_busy  = (state_q != StIdle);
  assign bus.dump_addr  = dump_addr_q;
  assign bus.dump_data  = dump_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q      <= '0;
      state_q     <= StIdle;
      idx_q       <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q      <= busy_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb_dump.sv
// Self-checking bench for regfile_sb_dump: directed read/write/scoreboard checks,
// and a queue of expected dump beats consumed by a stream monitor.
module tb_regfile_sb_dump;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned Depth = 1 << AddrW;

  logic clk;
  logic rst_n;

  regfile_sb_dump_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();
  regfile_sb_dump_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus0 ();

  regfile_sb_dump #(.DATA_W(DataW), .ADDR_W(AddrW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_sb_dump #(.DATA_W(DataW), .ADDR_W(AddrW), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } beat_t;

  beat_t            exp_q [$];
  logic [DataW-1:0] model [Depth];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               beats_seen = 0;
  bit               mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [DataW-1:0] obs,
                          input logic [DataW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_addr1 = '0;  bus.rd_addr2 = '0;
    bus.wa_en = 1'b0;   bus.wa_addr = '0;  bus.wa_data = '0;
    bus.wb_en = 1'b0;   bus.wb_addr = '0;  bus.wb_data = '0;
    bus.sb_set_en = 1'b0; bus.sb_set_addr = '0;
    bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    bus0.rd_addr1 = '0; bus0.rd_addr2 = '0;
    bus0.wa_en = 1'b0;  bus0.wa_addr = '0; bus0.wa_data = '0;
    bus0.wb_en = 1'b0;  bus0.wb_addr = '0; bus0.wb_data = '0;
    bus0.sb_set_en = 1'b0; bus0.sb_set_addr = '0;
    bus0.dump_start = 1'b0; bus0.dump_ready = 1'b0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < int'(Depth); i++) begin
      exp_q.push_back('{addr: AddrW'(i), data: model[i]});
    end
  endtask

  // Every accepted beat must match the head of the expected queue
  always @(negedge clk) begin
    if (mon_en && rst_n && bus.dump_valid && bus.dump_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("dump_unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check_eq("dump_addr", DataW'(bus.dump_addr), DataW'(b.addr));
        check_eq("dump_data", bus.dump_data, b.data);
        beats_seen++;
      end
    end
  end

  initial begin
    int cnt;
    idle_inputs();
    for (int i = 0; i < int'(Depth); i++) model[i] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state over all addresses
    for (int a = 0; a < int'(Depth); a++) begin
      bus.rd_addr1 = AddrW'(a);
      bus.rd_addr2 = AddrW'(Depth - 1 - a);
      #1;
      check_eq("rst_rd_data1", bus.rd_data1, '0);
      check_eq("rst_rd_data2", bus.rd_data2, '0);
      check_eq("rst_rd_busy", {30'd0, bus.rd_busy1, bus.rd_busy2}, '0);
    end
    check_eq("rst_dump_valid", {31'd0, bus.dump_valid}, '0);
    check_eq("rst_dump_busy", {31'd0, bus.dump_busy}, '0);

    // Entry 0 is hardwired to zero, even during the bypass cycle
    step();
    bus.rd_addr1 = '0;
    bus.wa_en = 1'b1; bus.wa_addr = '0; bus.wa_data = 32'hDEAD_BEEF;
    #1 check_eq("zero_bypass", bus.rd_data1, '0);
    step();
    bus.wa_en = 1'b0;
    #1 check_eq("zero_array", bus.rd_data1, '0);

    // A/B collision: A wins in bypass and in the array
    bus.rd_addr1 = 5'd5;
    bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'h1111_1111;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h2222_2222;
    #1 check_eq("collide_bypass", bus.rd_data1, 32'h1111_1111);
    step();
    model[5] = 32'h1111_1111;
    bus.wa_en = 1'b0; bus.wb_en = 1'b0;
    #1 check_eq("collide_array", bus.rd_data1, 32'h1111_1111);

    // Scoreboard set, then cleared by a bypassed B write
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd7;
    step();
    bus.sb_set_en = 1'b0;
    bus.rd_addr2 = 5'd7;
    #1 check_eq("sb_busy7", {31'd0, bus.rd_busy2}, 32'd1);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h42;
    #1 check_eq("sb_clear_bypass_busy", {31'd0, bus.rd_busy2}, 32'd0);
    check_eq("sb_clear_bypass_data", bus.rd_data2, 32'h42);
    step();
    model[7] = 32'h42;
    bus.wb_en = 1'b0;
    #1 check_eq("sb_cleared7", {31'd0, bus.rd_busy2}, 32'd0);
    check_eq("array7", bus.rd_data2, 32'h42);

    // Set and clear on the same cycle: set wins, data still written
    bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
    bus.wa_en = 1'b1; bus.wa_addr = 5'd9; bus.wa_data = 32'h99;
    step();
    model[9] = 32'h99;
    bus.wa_en = 1'b0;
    bus.rd_addr1 = 5'd9;
    #1 check_eq("set_wins_busy9", {31'd0, bus.rd_busy1}, 32'd1);
    check_eq("set_wins_data9", bus.rd_data1, 32'h99);
    step();  // sb_set still high: set on busy entry keeps it busy
    bus.sb_set_en = 1'b0;
    #1 check_eq("reset_busy9", {31'd0, bus.rd_busy1}, 32'd1);

    // Load entries i*0x10, then a full dump at full rate
    for (int i = 1; i < int'(Depth); i++) begin
      bus.wa_en = 1'b1; bus.wa_addr = AddrW'(i); bus.wa_data = DataW'(i * 16);
      step();
      model[i] = DataW'(i * 16);
    end
    bus.wa_en = 1'b0;
    push_dump();
    mon_en = 1'b1;
    beats_seen = 0;
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    cnt = 0;
    while (bus.dump_busy && cnt < 200) begin
      step();
      cnt++;
    end
    check_eq("dump_cycles", DataW'(cnt), 32'd64);
    check_eq("dump_beats", DataW'(beats_seen), DataW'(Depth));
    check_eq("dump_queue_empty", DataW'(exp_q.size()), 32'd0);

    // Stalled beat 3 while entry 3 is rewritten; mid-dump start is ignored
    push_dump();
    beats_seen = 0;
    bus.dump_ready = 1'b0;
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    cnt = 0;
    while (beats_seen < int'(Depth) && cnt < 400) begin
      if (bus.dump_valid) begin
        if (bus.dump_addr == 5'd3) begin
          bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'hFFFF;
          step();
          model[3] = 32'hFFFF;
          bus.wa_en = 1'b0;
          bus.dump_start = 1'b1;
          check_eq("stall_valid", {31'd0, bus.dump_valid}, 32'd1);
          check_eq("stall_addr", DataW'(bus.dump_addr), 32'd3);
          check_eq("stall_data", bus.dump_data, 32'h30);
          step();
          bus.dump_start = 1'b0;
          check_eq("stall_data_hold", bus.dump_data, 32'h30);
        end
        bus.dump_ready = 1'b1;
        step();
        bus.dump_ready = 1'b0;
      end else begin
        step();
      end
      cnt++;
    end
    check_eq("stall_dump_beats", DataW'(beats_seen), DataW'(Depth));
    check_eq("stall_dump_done", {31'd0, bus.dump_busy}, 32'd0);
    bus.rd_addr1 = 5'd3;
    #1 check_eq("entry3_new", bus.rd_data1, 32'hFFFF);

    // Reset during beat 10 aborts the dump
    push_dump();
    beats_seen = 0;
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    step();
    bus.dump_start = 1'b0;
    cnt = 0;
    while (!(bus.dump_valid && bus.dump_addr == 5'd10) && cnt < 100) begin
      step();
      cnt++;
    end
    check_eq("beat10_reached", {31'd0, bus.dump_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", {31'd0, bus.dump_valid}, 32'd0);
    check_eq("rst_async_busy", {31'd0, bus.dump_busy}, 32'd0);
    check_eq("beats_before_rst", DataW'(beats_seen), 32'd10);
    exp_q.delete();
    for (int a = 0; a < int'(Depth); a++) begin
      bus.rd_addr1 = AddrW'(a);
      bus.rd_addr2 = AddrW'(a);
      #1;
      check_eq("rst2_rd_data", bus.rd_data1, '0);
      check_eq("rst2_rd_busy", {31'd0, bus.rd_busy2}, '0);
    end
    mon_en = 1'b0;
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();

    // No-bypass build: same-cycle read sees the old value and the busy bit
    bus0.sb_set_en = 1'b1; bus0.sb_set_addr = 5'd6;
    step();
    bus0.sb_set_en = 1'b0;
    bus0.rd_addr1 = 5'd4;
    bus0.rd_addr2 = 5'd6;
    bus0.wa_en = 1'b1; bus0.wa_addr = 5'd4; bus0.wa_data = 32'h1234;
    bus0.wb_en = 1'b1; bus0.wb_addr = 5'd6; bus0.wb_data = 32'h5678;
    #1 check_eq("nb_old_data", bus0.rd_data1, 32'h0);
    check_eq("nb_busy_held", {31'd0, bus0.rd_busy2}, 32'd1);
    step();
    bus0.wa_en = 1'b0; bus0.wb_en = 1'b0;
    #1 check_eq("nb_new_data", bus0.rd_data1, 32'h1234);
    check_eq("nb_busy_cleared", {31'd0, bus0.rd_busy2}, 32'd0);
    check_eq("nb_new_data2", bus0.rd_data2, 32'h5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb_dump.md
Name: regfile_sb_dump

Overview:
- Parametrised successor to the core integer register file: generic data width and depth, optional hardwired-zero entry, two write ports, configurable write-to-read bypass.
- Adds a per-register scoreboard (busy bits) for issue-stage hazard detection.
- Replaces the flat all-register debug outputs with a valid/ready streaming dump engine.
- Sits between decode/issue (reads, scoreboard set) and writeback (ALU port A, load/FPU port B).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1: entry 0 reads 0, ignores writes, is never busy
BYPASS, 1, 1: same-cycle write data and busy-clear forwarded to read ports

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_data2  out  DATA_W  read port 2 data (combinational)
rd_busy1  out  1  scoreboard busy for rd_addr1
rd_busy2  out  1  scoreboard busy for rd_addr2
wa_en  in  1  write port A enable (ALU writeback, high priority)
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable (load/FPU writeback)
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
sb_set_en  in  1  mark destination busy (instruction issue)
sb_set_addr  in  ADDR_W  destination to mark busy
dump_start  in  1  pulse: start streaming all entries
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts beat
dump_addr  out  ADDR_W  index of current beat
dump_data  out  DATA_W  value of current beat
dump_busy  out  1  dump engine not IDLE

Behaviour:
- Reset (rst_n low, asynchronous): all entries 0; all busy bits 0; FSM IDLE; dump_valid/dump_addr/dump_data/dump_busy = 0. Reset mid-dump aborts it immediately; there is no resume.
- Writes:
  - Committed on the clock edge.
  - Port A or B to entry 0 is dropped when ZERO_REG=1.
  - A and B to the same address in the same cycle: A wins, B is dropped.
- Reads:
  - Combinational. Entry 0 returns 0 when ZERO_REG=1, regardless of pending writes.
  - BYPASS=1: if wa_en and wa_addr matches the read address, return wa_data; otherwise, if wb_en matches, return wb_data; otherwise return the array value.
  - BYPASS=0: return the array value only; new data is visible the cycle after the write.
- Scoreboard:
  - busy[i] is set at the edge by sb_set_en.
  - busy[i] is cleared at the edge by any enabled write (A or B) to i.
  - Set and clear to the same address in one cycle: set wins (the newer producer owns the register).
  - rd_busyN = busy[addr] AND NOT (BYPASS AND a same-cycle write to addr). It is forced to 0 for entry 0 when ZERO_REG=1.
  - A set on an already-busy entry leaves it busy.
- Dump FSM, states IDLE, LOAD, SEND:
  - IDLE: dump_valid=0. dump_start moves to LOAD with idx=0.
  - LOAD (1 cycle): dump_data <= array[idx] (pre-edge value, 0 for entry 0 if ZERO_REG); dump_addr <= idx; then SEND.
  - SEND: dump_valid=1. dump_addr/dump_data stay stable until dump_ready, even if idx is written meanwhile.
    - On dump_valid & dump_ready with idx==DEPTH-1: go to IDLE.
    - Otherwise: idx++ and go to LOAD.
  - Throughput: max 1 beat per 2 cycles; a full dump is 2*DEPTH cycles with dump_ready tied high.
  - dump_start outside IDLE is ignored.
  - dump_busy=1 in LOAD and SEND.
  - Register writes and the scoreboard operate normally during a dump.
- Widths: idx is ADDR_W bits. No overflow is possible, because the terminal test precedes the increment.

Test Plan:
- Reset then read all addresses -> rd_data1/2=0, rd_busy1/2=0, dump_valid=0; wa_en addr 0 data 0xDEADBEEF -> addr 0 still reads 0.
- wa_en addr 5 data 0x11111111 plus wb_en addr 5 data 0x22222222 in the same cycle, rd_addr1=5 -> bypass shows 0x11111111; next cycle the array holds 0x11111111.
- sb_set addr 7, next cycle rd_addr2=7 -> rd_busy2=1; wb_en addr 7 data 0x42 -> rd_busy2=0 and rd_data2=0x42 in that cycle (BYPASS=1); set and write to 9 in the same cycle -> busy[9]=1 afterwards.
- Load entries i=i*0x10, dump_start, dump_ready=1 -> 32 beats, addr 0..31, data 0x0..0x1F0, dump_busy falls after 64 cycles.
- Dump with dump_ready held low on beat 3 while wa writes entry 3 = 0xFFFF -> dump_data holds the old 0x30 until accepted; a second dump_start mid-dump is ignored.
- rst_n low during beat 10 -> dump_valid drops asynchronously, all entries and busy bits read 0; BYPASS=0 build: write then same-cycle read returns the old value.
